// File: rtl/decode_pkg.sv
//------------------------------------------------------------------------------
// Module  : decode_pkg
// Brief   : Control-word type and result-source encodings for the decode stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

    localparam int CTRL_W = 12;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       jump_src;
        logic       a_type;
    } ctrl_t;

    function automatic logic isLoad(input ctrl_t c);
        return c.result_src == RES_MEM;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//------------------------------------------------------------------------------
// Module  : regfile_2r1w
// Brief   : Two-read one-write register file, x0 hardwired to zero, a0 tap.
//           DECODE_BYPASS_EN enables write-first forwarding on all read ports.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A0_IDX  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] a1,
    input  logic [A_WIDTH-1:0] a2,
    input  logic               we3,
    input  logic [A_WIDTH-1:0] a3,
    input  logic [D_WIDTH-1:0] wd3,
    output logic [D_WIDTH-1:0] rd1,
    output logic [D_WIDTH-1:0] rd2,
    output logic [D_WIDTH-1:0] a0
);

    localparam int                 c_NREGS = 1 << A_WIDTH;
    localparam logic [A_WIDTH-1:0] c_A0    = A_WIDTH'(A0_IDX);

    logic [D_WIDTH-1:0] r_regs [c_NREGS];
    logic               w_wrEn;
    logic               w_byp1;
    logic               w_byp2;
    logic               w_bypA0;

    assign w_wrEn = we3 && (a3 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[a3] <= wd3;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign w_byp1  = w_wrEn && (a1 == a3);
    assign w_byp2  = w_wrEn && (a2 == a3);
    assign w_bypA0 = w_wrEn && (c_A0 == a3);
`else
    assign w_byp1  = 1'b0;
    assign w_byp2  = 1'b0;
    assign w_bypA0 = 1'b0;
`endif

    // x0 reads zero even if its storage was never touched
    assign rd1 = (a1 == '0)   ? '0 : (w_byp1  ? wd3 : r_regs[a1]);
    assign rd2 = (a2 == '0)   ? '0 : (w_byp2  ? wd3 : r_regs[a2]);
    assign a0  = (c_A0 == '0) ? '0 : (w_bypA0 ? wd3 : r_regs[c_A0]);

endmodule

`default_nettype wire

// File: rtl/decode_pipe_stage.sv
//------------------------------------------------------------------------------
// Module  : decode_pipe_stage
// Brief   : Decode stage: register-file read, D/E pipeline register and
//           load-use stall. Optional macro DECODE_BYPASS_EN (WB forwarding).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A0_IDX  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] instr_d,
    input  logic               valid_d,
    input  logic [CTRL_W-1:0]  ctrl_d,
    input  logic [D_WIDTH-1:0] imm_ext_d,
    input  logic [D_WIDTH-1:0] pc_d,
    input  logic [D_WIDTH-1:0] pc_plus4_d,
    input  logic               flush_e,
    input  logic               we3,
    input  logic [A_WIDTH-1:0] a3,
    input  logic [D_WIDTH-1:0] wd3,
    output logic               stall_d,
    output logic               valid_e,
    output logic [CTRL_W-1:0]  ctrl_e,
    output logic [D_WIDTH-1:0] rd1_e,
    output logic [D_WIDTH-1:0] rd2_e,
    output logic [D_WIDTH-1:0] imm_ext_e,
    output logic [D_WIDTH-1:0] pc_e,
    output logic [D_WIDTH-1:0] pc_plus4_e,
    output logic [A_WIDTH-1:0] rs1_e,
    output logic [A_WIDTH-1:0] rs2_e,
    output logic [A_WIDTH-1:0] rd_e,
    output logic [D_WIDTH-1:0] a0
);

    typedef struct packed {
        logic               valid;
        ctrl_t              ctrl;
        logic [D_WIDTH-1:0] rd1;
        logic [D_WIDTH-1:0] rd2;
        logic [D_WIDTH-1:0] imm;
        logic [D_WIDTH-1:0] pc;
        logic [D_WIDTH-1:0] pc4;
        logic [A_WIDTH-1:0] rs1;
        logic [A_WIDTH-1:0] rs2;
        logic [A_WIDTH-1:0] rd;
    } eStage_t;

    eStage_t            r_e;
    eStage_t            w_eNext;
    ctrl_t              w_ctrlD;
    logic [4:0]         w_rs1Fld;
    logic [4:0]         w_rs2Fld;
    logic [4:0]         w_rdFld;
    logic [A_WIDTH-1:0] w_rs1;
    logic [A_WIDTH-1:0] w_rs2;
    logic [A_WIDTH-1:0] w_rd;
    logic [D_WIDTH-1:0] w_rd1;
    logic [D_WIDTH-1:0] w_rd2;
    logic               w_stall;
    logic               w_unused;

    assign w_ctrlD  = ctrl_t'(ctrl_d);
    assign w_rs1Fld = instr_d[19:15];
    assign w_rs2Fld = instr_d[24:20];
    assign w_rdFld  = instr_d[11:7];
    assign w_rs1    = A_WIDTH'(w_rs1Fld);
    assign w_rs2    = A_WIDTH'(w_rs2Fld);
    assign w_rd     = A_WIDTH'(w_rdFld);
    assign w_unused = ^{instr_d[D_WIDTH-1:25], instr_d[14:12], instr_d[6:0]};

    regfile_2r1w #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .A0_IDX  (A0_IDX)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .a1  (w_rs1),
        .a2  (w_rs2),
        .we3 (we3),
        .a3  (a3),
        .wd3 (wd3),
        .rd1 (w_rd1),
        .rd2 (w_rd2),
        .a0  (a0)
    );

    // rs2 compared even when unused: cheaper than decoding the format
    assign w_stall = valid_d && r_e.valid && isLoad(r_e.ctrl) && (r_e.rd != '0) &&
                     ((r_e.rd == w_rs1) || (r_e.rd == w_rs2));

    always_comb begin
        w_eNext       = '0;
        w_eNext.valid = valid_d;
        w_eNext.ctrl  = valid_d ? w_ctrlD : '0;
        w_eNext.rd1   = w_rd1;
        w_eNext.rd2   = w_rd2;
        w_eNext.imm   = imm_ext_d;
        w_eNext.pc    = pc_d;
        w_eNext.pc4   = pc_plus4_d;
        w_eNext.rs1   = w_rs1;
        w_eNext.rs2   = w_rs2;
        w_eNext.rd    = w_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= '0;
        end else if (flush_e || w_stall) begin
            r_e <= '0;
        end else begin
            r_e <= w_eNext;
        end
    end

    assign stall_d    = w_stall;
    assign valid_e    = r_e.valid;
    assign ctrl_e     = r_e.ctrl;
    assign rd1_e      = r_e.rd1;
    assign rd2_e      = r_e.rd2;
    assign imm_ext_e  = r_e.imm;
    assign pc_e       = r_e.pc;
    assign pc_plus4_e = r_e.pc4;
    assign rs1_e      = r_e.rs1;
    assign rs2_e      = r_e.rs2;
    assign rd_e       = r_e.rd;

endmodule

`default_nettype wire
